// File: rtl/decode_out_pkg_hdl.sv
// -----------------------------------------------------------------------------
// decode_out_pkg_hdl
// Shared constants and types for the LC-3 decode stage: opcode values, ALU
// operation codes, writeback selects, pcselect1 codes and the packed layout
// of the 6-bit E_Control bus.
// -----------------------------------------------------------------------------
package decode_out_pkg_hdl;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    // Writeback source
    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_LEA = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;

    // Address offset source for the PC/address adder
    localparam logic [1:0] PC1_NONE = 2'b00;
    localparam logic [1:0] PC1_OFF9 = 2'b01;
    localparam logic [1:0] PC1_OFF6 = 2'b10;
    localparam logic [1:0] PC1_ZERO = 2'b11;

    // E_Control = {alu[1:0], pcsel1[1:0], pcsel2, op2sel}
    typedef struct packed {
        logic [1:0] alu;
        logic [1:0] pcsel1;
        logic       pcsel2;  // 1 = npc base, 0 = register base
        logic       op2sel;  // 1 = register operand, 0 = imm5/none
    } e_ctrl_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// -----------------------------------------------------------------------------
// decode_ctrl_lut
// Purely combinational control decode from opcode and IR[5].
// Ports:
//   opcode      in  4  instruction bits [15:12]
//   ir5         in  1  instruction bit 5 (immediate flag for ADD/AND)
//   e_ctrl      out 6  execute controls (e_ctrl_t)
//   w_ctrl      out 2  writeback select
//   mem_ctrl    out 1  indirect memory access
// -----------------------------------------------------------------------------
module decode_ctrl_lut
    import decode_out_pkg_hdl::*;
(
    input  logic [3:0] opcode,
    input  logic       ir5,
    output e_ctrl_t    e_ctrl,
    output logic [1:0] w_ctrl,
    output logic       mem_ctrl
);

    always_comb begin
        // Unlisted opcodes (JSR, TRAP, RTI, reserved) keep all-zero controls.
        e_ctrl   = '0;
        w_ctrl   = W_ALU;
        mem_ctrl = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                e_ctrl.alu    = ALU_ADD;
                e_ctrl.op2sel = ~ir5;
            end
            OP_AND: begin
                e_ctrl.alu    = ALU_AND;
                e_ctrl.op2sel = ~ir5;
            end
            OP_NOT: begin
                e_ctrl.alu = ALU_NOT;
            end
            OP_BR: begin
                e_ctrl.pcsel1 = PC1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
            end
            OP_JMP: begin
                e_ctrl.pcsel1 = PC1_ZERO;
            end
            OP_LD, OP_LDI: begin
                e_ctrl.pcsel1 = PC1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                w_ctrl        = W_MEM;
                mem_ctrl      = (opcode == OP_LDI);
            end
            OP_LDR: begin
                e_ctrl.pcsel1 = PC1_OFF6;
                w_ctrl        = W_MEM;
            end
            OP_LEA: begin
                e_ctrl.pcsel1 = PC1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                w_ctrl        = W_LEA;
            end
            OP_ST, OP_STI: begin
                e_ctrl.pcsel1 = PC1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                mem_ctrl      = (opcode == OP_STI);
            end
            OP_STR: begin
                e_ctrl.pcsel1 = PC1_OFF6;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// LC-3 decode pipeline stage. Captures the fetched instruction and next-PC and
// registers the decoded control bundle for the execute stage. One-cycle
// latency, holds while enable_decode is low.
// Ports:
//   clock          in  1   pipeline clock
//   reset          in  1   synchronous, active-high; clears all outputs
//   enable_decode  in  1   1 = capture/decode, 0 = hold
//   dout           in  16  instruction word
//   npc_in         in  16  next PC from fetch
//   IR             out 16  registered instruction
//   npc_out        out 16  registered next PC
//   E_Control      out 6   {alu[1:0], pcsel1[1:0], pcsel2, op2sel}
//   W_Control      out 2   writeback select
//   Mem_Control    out 1   indirect memory access (LDI/STI)
// -----------------------------------------------------------------------------
module decode_stage
    import decode_out_pkg_hdl::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control
);

    e_ctrl_t    e_nxt;
    logic [1:0] w_nxt;
    logic       mem_nxt;

    decode_ctrl_lut u_lut (
        .opcode   (dout[15:12]),
        .ir5      (dout[5]),
        .e_ctrl   (e_nxt),
        .w_ctrl   (w_nxt),
        .mem_ctrl (mem_nxt)
    );

    // Reset has priority over enable; all outputs are registered so nothing
    // on the input side reaches the outputs between edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            IR          <= '0;
            npc_out     <= '0;
            E_Control   <= '0;
            W_Control   <= '0;
            Mem_Control <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_Control   <= e_nxt;
            W_Control   <= w_nxt;
            Mem_Control <= mem_nxt;
        end
    end

endmodule
